// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUNNING,
    ST_PAUSED,
    ST_EXPIRED
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [3:0] digit_t;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the countdown chain: loads, or decrements when a borrow arrives.
module bcd_digit_cell
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       borrow_in,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       borrow_out
);

  digit_t digit_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_p0 <= 4'd0;
    end else if (load) begin
      digit_p0 <= load_val;
    end else if (borrow_in) begin
      digit_p0 <= (digit_p0 == 4'd0) ? BCD_MAX : digit_p0 - 4'd1;
    end
  end

  // A zero digit that is asked to decrement wraps to 9 and borrows from above.
  assign borrow_out = borrow_in & (digit_p0 == 4'd0);
  assign digit      = digit_p0;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Prescaled multi-digit BCD countdown timer with pause, expire pulse and load clamping.
// Define TIMER_AUTO_RELOAD_EN to reload the last loaded value after reaching zero.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] start_value,
  input  logic                    enable,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    zero,
  output logic                    expire,
  output logic                    busy,
  output logic                    load_err
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > BCD_MAX) r[4*i +: 4] = BCD_MAX;
    end
    return r;
  endfunction

  function automatic logic has_bad_nibble(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

  state_t          state_p0, state_nxt;
  logic [PW-1:0]   presc_p0;
  logic            expire_p0;
  logic            load_err_p0;
  logic            count_en;
  logic            tick;
  logic            at_one;
  logic            at_floor;
  logic            reload_tick;
  logic            cell_load;
  logic [W-1:0]    cell_val;
  logic [NUM_DIGITS:0] borrow;

  assign count_en = (state_p0 == ST_RUNNING) && enable;
  assign tick     = count_en && (presc_p0 == PW'(TICK_DIV - 1));
  assign at_one   = (digits == W'(1));
  assign borrow[0] = tick;
  // A borrow out of the top digit means a tick arrived while already at zero.
  assign at_floor = borrow[NUM_DIGITS];

`ifdef TIMER_AUTO_RELOAD_EN
  logic [W-1:0] saved_p0;

  always_ff @(posedge clk) begin
    if (rst)       saved_p0 <= '0;
    else if (load) saved_p0 <= clamp_bcd(start_value);
  end

  assign reload_tick = at_floor;
  assign cell_val    = load ? clamp_bcd(start_value) : saved_p0;
`else
  assign reload_tick = 1'b0;
  assign cell_val    = clamp_bcd(start_value);
`endif

  assign cell_load = load | reload_tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .borrow_in  (borrow[g]),
      .load       (cell_load),
      .load_val   (cell_val[4*g +: 4]),
      .digit      (digits[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  // Stage p0: control state, prescaler and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= ST_IDLE;
      presc_p0    <= '0;
      expire_p0   <= 1'b0;
      load_err_p0 <= 1'b0;
    end else begin
      state_p0  <= state_nxt;
      expire_p0 <= !load && tick && at_one;
      if (load) begin
        presc_p0    <= '0;
        load_err_p0 <= has_bad_nibble(start_value);
      end else if (count_en) begin
        presc_p0 <= tick ? '0 : presc_p0 + PW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state_p0;
    if (load) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_p0)
        ST_IDLE:    if (enable && !zero) state_nxt = ST_RUNNING;
        ST_RUNNING: begin
`ifdef TIMER_AUTO_RELOAD_EN
          if (!enable) state_nxt = ST_PAUSED;
`else
          if ((tick && at_one) || at_floor) state_nxt = ST_EXPIRED;
          else if (!enable)                 state_nxt = ST_PAUSED;
`endif
        end
        ST_PAUSED:  if (enable) state_nxt = ST_RUNNING;
        ST_EXPIRED: state_nxt = ST_EXPIRED;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  assign zero     = (digits == '0);
  assign expire   = expire_p0;
  assign busy     = (state_p0 == ST_RUNNING);
  assign load_err = load_err_p0;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: two instances with different digit counts and prescalers.
module tb_bcd_countdown_timer;

  logic clk;

  // Instance A: 3 digits, tick every cycle
  logic        rst_a, load_a, en_a;
  logic [11:0] sv_a, dig_a;
  logic        zero_a, exp_a, busy_a, lerr_a;

  // Instance B: 2 digits, tick every 4 cycles
  logic        rst_b, load_b, en_b;
  logic [7:0]  sv_b, dig_b;
  logic        zero_b, exp_b, busy_b, lerr_b;

  int n_checks;
  int n_fail;

  bcd_countdown_timer #(.NUM_DIGITS(3), .TICK_DIV(1)) dut_a (
    .clk(clk), .rst(rst_a), .load(load_a), .start_value(sv_a), .enable(en_a),
    .digits(dig_a), .zero(zero_a), .expire(exp_a), .busy(busy_a), .load_err(lerr_a)
  );

  bcd_countdown_timer #(.NUM_DIGITS(2), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst(rst_b), .load(load_b), .start_value(sv_b), .enable(en_b),
    .digits(dig_b), .zero(zero_b), .expire(exp_b), .busy(busy_b), .load_err(lerr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_a = 1'b1; load_a = 1'b0; en_a = 1'b0; sv_a = '0;
    rst_b = 1'b1; load_b = 1'b0; en_b = 1'b0; sv_b = '0;
    step();
    chk("rst_a_digits", 32'(dig_a), 32'h000);
    chk("rst_a_zero", 32'(zero_a), 32'd1);
    chk("rst_a_expire", 32'(exp_a), 32'd0);
    chk("rst_a_busy", 32'(busy_a), 32'd0);
    chk("rst_a_load_err", 32'(lerr_a), 32'd0);
    chk("rst_b_digits", 32'(dig_b), 32'h00);
    chk("rst_b_zero", 32'(zero_b), 32'd1);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Test 1: borrow across two digits
    load_a = 1'b1; sv_a = 12'h100;
    step();
    chk("t1_load", 32'(dig_a), 32'h100);
    chk("t1_idle", 32'(busy_a), 32'd0);
    load_a = 1'b0; en_a = 1'b1;
    step();
    chk("t1_busy", 32'(busy_a), 32'd1);
    chk("t1_hold_first", 32'(dig_a), 32'h100);
    step();
    chk("t1_099", 32'(dig_a), 32'h099);
    step();
    chk("t1_098", 32'(dig_a), 32'h098);
    chk("t1_nonzero", 32'(zero_a), 32'd0);
    en_a = 1'b0;

    // Test 2: prescaled count to expiry
    load_b = 1'b1; sv_b = 8'h02;
    step();
    chk("t2_load", 32'(dig_b), 32'h02);
    load_b = 1'b0; en_b = 1'b1;
    step();
    repeat (3) step();
    chk("t2_pre_tick", 32'(dig_b), 32'h02);
    step();
    chk("t2_01", 32'(dig_b), 32'h01);
    repeat (3) step();
    chk("t2_hold_01", 32'(dig_b), 32'h01);
    chk("t2_no_early_expire", 32'(exp_b), 32'd0);
    step();
    chk("t2_00", 32'(dig_b), 32'h00);
    chk("t2_zero", 32'(zero_b), 32'd1);
    chk("t2_expire", 32'(exp_b), 32'd1);
    chk("t2_not_busy", 32'(busy_b), 32'd0);
    step();
    chk("t2_expire_drop", 32'(exp_b), 32'd0);
    repeat (3) step();
    chk("t2_held_00", 32'(dig_b), 32'h00);
    chk("t2_held_expire", 32'(exp_b), 32'd0);
    chk("t2_held_busy", 32'(busy_b), 32'd0);

    // Test 3: pause mid-prescale, no tick lost or gained
    load_b = 1'b1; sv_b = 8'h15;
    step();
    chk("t3_load", 32'(dig_b), 32'h15);
    chk("t3_load_idle", 32'(busy_b), 32'd0);
    load_b = 1'b0;
    step();
    repeat (2) step();
    en_b = 1'b0;
    step();
    repeat (10) step();
    chk("t3_frozen", 32'(dig_b), 32'h15);
    chk("t3_paused", 32'(busy_b), 32'd0);
    en_b = 1'b1;
    step();
    chk("t3_resumed", 32'(busy_b), 32'd1);
    chk("t3_resume_hold", 32'(dig_b), 32'h15);
    step();
    chk("t3_one_left", 32'(dig_b), 32'h15);
    step();
    chk("t3_14", 32'(dig_b), 32'h14);
    repeat (3) step();
    chk("t3_hold_14", 32'(dig_b), 32'h14);
    step();
    chk("t3_13", 32'(dig_b), 32'h13);

    // Test 4: clamp on load, then zero load with enable held
    load_b = 1'b1; sv_b = 8'h3A;
    step();
    chk("t4_clamp", 32'(dig_b), 32'h39);
    chk("t4_err", 32'(lerr_b), 32'd1);
    load_b = 1'b0;
    step();
    step();
    chk("t4_err_sticky", 32'(lerr_b), 32'd1);
    load_b = 1'b1; sv_b = 8'h00;
    step();
    chk("t4_zero_load", 32'(dig_b), 32'h00);
    chk("t4_zero_flag", 32'(zero_b), 32'd1);
    chk("t4_err_clear", 32'(lerr_b), 32'd0);
    chk("t4_no_expire", 32'(exp_b), 32'd0);
    load_b = 1'b0;
    step();
    chk("t4_stay_idle", 32'(busy_b), 32'd0);
    chk("t4_no_expire2", 32'(exp_b), 32'd0);
    step();
    chk("t4_no_expire3", 32'(exp_b), 32'd0);

    // Test 5: load on the final tick, then reset mid-count
    load_a = 1'b1; sv_a = 12'h002;
    step();
    chk("t5_load", 32'(dig_a), 32'h002);
    load_a = 1'b0; en_a = 1'b1;
    step();
    step();
    chk("t5_001", 32'(dig_a), 32'h001);
    load_a = 1'b1; sv_a = 12'h050;
    step();
    chk("t5_load_wins", 32'(dig_a), 32'h050);
    chk("t5_no_expire", 32'(exp_a), 32'd0);
    chk("t5_idle", 32'(busy_a), 32'd0);
    load_a = 1'b0;
    step();
    chk("t5_no_expire2", 32'(exp_a), 32'd0);
    chk("t5_run", 32'(busy_a), 32'd1);
    step();
    chk("t5_049", 32'(dig_a), 32'h049);
    load_a = 1'b1; sv_a = 12'h0A5;
    step();
    chk("t5_clamp", 32'(dig_a), 32'h095);
    chk("t5_err", 32'(lerr_a), 32'd1);
    load_a = 1'b0;
    step();
    step();
    chk("t5_094", 32'(dig_a), 32'h094);
    rst_a = 1'b1; load_a = 1'b1; sv_a = 12'h123;
    step();
    chk("t5_rst_digits", 32'(dig_a), 32'h000);
    chk("t5_rst_zero", 32'(zero_a), 32'd1);
    chk("t5_rst_expire", 32'(exp_a), 32'd0);
    chk("t5_rst_busy", 32'(busy_a), 32'd0);
    chk("t5_rst_err", 32'(lerr_a), 32'd0);
    rst_a = 1'b0; load_a = 1'b0; en_a = 1'b0;
    step();

`ifdef TIMER_AUTO_RELOAD_EN
    // Test 6: periodic reload, period value+1 ticks
    begin
      logic [11:0] seq [8];
      seq = '{12'h002, 12'h001, 12'h000, 12'h003, 12'h002, 12'h001, 12'h000, 12'h003};
      load_a = 1'b1; sv_a = 12'h003;
      step();
      chk("t6_load", 32'(dig_a), 32'h003);
      load_a = 1'b0; en_a = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
        step();
        chk($sformatf("t6_digits_%0d", i), 32'(dig_a), 32'(seq[i]));
        chk($sformatf("t6_expire_%0d", i), 32'(exp_a), (seq[i] == 12'h000) ? 32'd1 : 32'd0);
        chk($sformatf("t6_busy_%0d", i), 32'(busy_a), 32'd1);
      end
      en_a = 1'b0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
